// File: rtl/gate_table_sweeper.sv
// Registered two-input bitwise gate with a programmable 4-bit truth table.
// Direct mode uses a valid/ready handshake; sweep mode runs every (a, b) pair and folds results into a signature.
module gate_table_sweeper #(
  parameter int         WIDTH        = 4,
  parameter logic [3:0] DEFAULT_FUNC = 4'b0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             func_we,
  input  logic [3:0]       func_in,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_func;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_sig;
  logic             r_out_valid;

  logic             w_sweeping;
  logic             w_take;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_rot;

  function automatic logic [WIDTH-1:0] eval_gate(input logic [3:0]       tt,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  assign w_sweeping = (r_state == SWEEP);
  // A direct operand is consumed only when IDLE and no sweep request competes for the same cycle.
  assign w_take     = (r_state == IDLE) & in_valid & ~start;
  assign w_cnt_last = &r_cnt;
  assign w_op_a     = w_sweeping ? r_cnt[CW-1:WIDTH] : a_in;
  assign w_op_b     = w_sweeping ? r_cnt[WIDTH-1:0]  : b_in;
  assign w_f        = eval_gate(r_func, w_op_a, w_op_b);
  // Rotate-left by one; collapses to identity when WIDTH == 1.
  assign w_rot      = (r_sig << 1) | (r_sig >> (WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SWEEP;
      SWEEP:   if (w_cnt_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE) & ~start;
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func      <= DEFAULT_FUNC;
      r_cnt       <= '0;
      r_s         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_sig       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_take | w_sweeping;
      // Results always use the pre-edge func, so a same-cycle func write affects only later results.
      if (w_take || w_sweeping) begin
        r_s <= w_f;
        r_x <= w_op_a;
        r_y <= w_op_b;
      end
      if (r_state == IDLE) begin
        if (func_we) r_func <= func_in;
        if (start) begin
          r_cnt <= '0;
          r_sig <= '0;
        end
      end
      if (w_sweeping) begin
        r_sig <= w_rot ^ w_f;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign s         = r_s;
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign out_valid = r_out_valid;
  assign sig       = r_sig;

endmodule

// File: tb/tb_gate_table_sweeper.sv
// Directed bench for gate_table_sweeper at WIDTH = 1, 2 and 4 sharing one clock and reset.
module tb_gate_table_sweeper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       func_we_1, start_1, in_valid_1, in_ready_1, out_valid_1, busy_1, done_1;
  logic [3:0] func_in_1;
  logic [0:0] a_1, b_1, s_1, x_1, y_1, sig_1;

  logic       func_we_2, start_2, in_valid_2, in_ready_2, out_valid_2, busy_2, done_2;
  logic [3:0] func_in_2;
  logic [1:0] a_2, b_2, s_2, x_2, y_2, sig_2;

  logic       func_we_4, start_4, in_valid_4, in_ready_4, out_valid_4, busy_4, done_4;
  logic [3:0] func_in_4;
  logic [3:0] a_4, b_4, s_4, x_4, y_4, sig_4;

  gate_table_sweeper #(.WIDTH(1), .DEFAULT_FUNC(4'b0010)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .func_we(func_we_1), .func_in(func_in_1), .start(start_1),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .a_in(a_1), .b_in(b_1), .s(s_1),
    .x_out(x_1), .y_out(y_1), .out_valid(out_valid_1), .busy(busy_1), .done(done_1), .sig(sig_1));

  gate_table_sweeper #(.WIDTH(2), .DEFAULT_FUNC(4'b0010)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .func_we(func_we_2), .func_in(func_in_2), .start(start_2),
    .in_valid(in_valid_2), .in_ready(in_ready_2), .a_in(a_2), .b_in(b_2), .s(s_2),
    .x_out(x_2), .y_out(y_2), .out_valid(out_valid_2), .busy(busy_2), .done(done_2), .sig(sig_2));

  gate_table_sweeper #(.WIDTH(4), .DEFAULT_FUNC(4'b0010)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .func_we(func_we_4), .func_in(func_in_4), .start(start_4),
    .in_valid(in_valid_4), .in_ready(in_ready_4), .a_in(a_4), .b_in(b_4), .s(s_4),
    .x_out(x_4), .y_out(y_4), .out_valid(out_valid_4), .busy(busy_4), .done(done_4), .sig(sig_4));

  // W1 sweep with ~a&b: {x,y,s} per result
  logic [2:0] w1_xys [4] = '{3'b000, 3'b011, 3'b100, 3'b110};
  // Direct vectors with ~a&b worked by hand
  logic [3:0] va [4] = '{4'b0101, 4'b1111, 4'b0000, 4'b1100};
  logic [3:0] vb [4] = '{4'b0011, 4'b0000, 4'b1111, 4'b1010};
  logic [3:0] vs [4] = '{4'b0010, 4'b0000, 4'b1111, 4'b0010};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({s_4, x_4, y_4, sig_4, out_valid_4, done_4, busy_4, in_ready_4} !== {16'h0, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_w4: got %h required %h",
               {s_4, x_4, y_4, sig_4, out_valid_4, done_4, busy_4, in_ready_4}, {16'h0, 4'b0001});
    end
    n_cmp++;
    if ({s_1, x_1, y_1, sig_1, out_valid_1, done_1, busy_1, in_ready_1} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_w1: got %b required 00000001",
               {s_1, x_1, y_1, sig_1, out_valid_1, done_1, busy_1, in_ready_1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep_w1;
    int busy_cnt;
    start_1 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_1 !== 1'b0) begin
      n_err++;
      $display("FAIL w1_in_ready_on_start: got %b required 0", in_ready_1);
    end
    tick();
    start_1 = 1'b0;
    busy_cnt = busy_1 ? 1 : 0;
    n_cmp++;
    if ({busy_1, out_valid_1} !== 2'b10) begin
      n_err++;
      $display("FAIL w1_sweep_entry: got %b required 10", {busy_1, out_valid_1});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy_1) busy_cnt++;
      n_cmp++;
      if ({out_valid_1, done_1, x_1, y_1, s_1} !== {1'b1, k == 3, w1_xys[k]}) begin
        n_err++;
        $display("FAIL w1_result_%0d: got %b required %b", k,
                 {out_valid_1, done_1, x_1, y_1, s_1}, {1'b1, k == 3, w1_xys[k]});
      end
    end
    n_cmp++;
    if (sig_1 !== 1'b1) begin
      n_err++;
      $display("FAIL w1_sig: got %b required 1", sig_1);
    end
    tick();
    n_cmp++;
    if ({busy_1, out_valid_1, done_1} !== 3'b000) begin
      n_err++;
      $display("FAIL w1_after_done: got %b required 000", {busy_1, out_valid_1, done_1});
    end
    n_cmp++;
    if (busy_cnt !== 5) begin
      n_err++;
      $display("FAIL w1_busy_cycles: got %0d required 5", busy_cnt);
    end
  endtask

  task automatic test_direct;
    a_4 = va[0];
    b_4 = vb[0];
    in_valid_4 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_4 !== 1'b1) begin
      n_err++;
      $display("FAIL direct_in_ready: got %b required 1", in_ready_4);
    end
    for (int k = 0; k < 4; k++) begin
      a_4 = va[k];
      b_4 = vb[k];
      in_valid_4 = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid_4, x_4, y_4, s_4} !== {1'b1, va[k], vb[k], vs[k]}) begin
        n_err++;
        $display("FAIL direct_%0d: got %h required %h", k,
                 {out_valid_4, x_4, y_4, s_4}, {1'b1, va[k], vb[k], vs[k]});
      end
    end
    in_valid_4 = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid_4, s_4} !== {1'b0, vs[3]}) begin
      n_err++;
      $display("FAIL direct_idle_hold: got %b required %b", {out_valid_4, s_4}, {1'b0, vs[3]});
    end
  endtask

  task automatic test_func;
    func_we_4 = 1'b1;
    func_in_4 = 4'b1110;
    tick();
    func_we_4 = 1'b0;
    a_4 = 4'b0101;
    b_4 = 4'b0011;
    in_valid_4 = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid_4, s_4} !== 5'b1_0111) begin
      n_err++;
      $display("FAIL func_or: got %b required 10111", {out_valid_4, s_4});
    end
    func_we_4 = 1'b1;
    func_in_4 = 4'b1000;
    tick();
    func_we_4 = 1'b0;
    n_cmp++;
    if ({out_valid_4, s_4} !== 5'b1_0111) begin
      n_err++;
      $display("FAIL func_same_cycle_old: got %b required 10111", {out_valid_4, s_4});
    end
    tick();
    in_valid_4 = 1'b0;
    n_cmp++;
    if ({out_valid_4, s_4} !== 5'b1_0001) begin
      n_err++;
      $display("FAIL func_and_next: got %b required 10001", {out_valid_4, s_4});
    end
    // Attempt a func write while the W1 unit sweeps; it must be ignored
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    func_we_1 = 1'b1;
    func_in_1 = 4'b0000;
    repeat (4) tick();
    func_we_1 = 1'b0;
    tick();
    n_cmp++;
    if (busy_1 !== 1'b0) begin
      n_err++;
      $display("FAIL func_sweep_idle: got %b required 0", busy_1);
    end
    a_1 = 1'b0;
    b_1 = 1'b1;
    in_valid_1 = 1'b1;
    tick();
    in_valid_1 = 1'b0;
    n_cmp++;
    if ({out_valid_1, s_1} !== 2'b11) begin
      n_err++;
      $display("FAIL func_we_in_sweep_ignored: got %b required 11", {out_valid_1, s_1});
    end
  endtask

  task automatic test_start_priority;
    start_1 = 1'b1;
    in_valid_1 = 1'b1;
    a_1 = 1'b1;
    b_1 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_1 !== 1'b0) begin
      n_err++;
      $display("FAIL prio_in_ready: got %b required 0", in_ready_1);
    end
    tick();
    start_1 = 1'b0;
    in_valid_1 = 1'b0;
    n_cmp++;
    if ({busy_1, out_valid_1} !== 2'b10) begin
      n_err++;
      $display("FAIL prio_no_direct_result: got %b required 10", {busy_1, out_valid_1});
    end
    tick();
    n_cmp++;
    if ({out_valid_1, x_1, y_1, s_1} !== 4'b1000) begin
      n_err++;
      $display("FAIL prio_first_sweep: got %b required 1000", {out_valid_1, x_1, y_1, s_1});
    end
    repeat (3) tick();
    n_cmp++;
    if ({done_1, x_1, y_1, sig_1} !== 4'b1111) begin
      n_err++;
      $display("FAIL prio_done: got %b required 1111", {done_1, x_1, y_1, sig_1});
    end
    tick();
    n_cmp++;
    if ({busy_1, out_valid_1} !== 2'b00) begin
      n_err++;
      $display("FAIL prio_tail: got %b required 00", {busy_1, out_valid_1});
    end
  endtask

  task automatic test_reset_mid_sweep;
    int busy_cnt;
    int n_res;
    logic [1:0] ex, ey;
    start_2 = 1'b1;
    tick();
    start_2 = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if ({out_valid_2, x_2, y_2, s_2} !== 7'b1_01_10_10) begin
      n_err++;
      $display("FAIL w2_7th_result: got %b required 1011010", {out_valid_2, x_2, y_2, s_2});
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_2, x_2, y_2, sig_2, out_valid_2, busy_2, done_2, in_ready_2} !== 12'b0000_0000_0001) begin
      n_err++;
      $display("FAIL w2_async_reset: got %b required 000000000001",
               {s_2, x_2, y_2, sig_2, out_valid_2, busy_2, done_2, in_ready_2});
    end
    rst_n = 1'b1;
    tick();
    a_2 = 2'b01;
    b_2 = 2'b10;
    in_valid_2 = 1'b1;
    tick();
    in_valid_2 = 1'b0;
    n_cmp++;
    if ({out_valid_2, s_2} !== 3'b1_10) begin
      n_err++;
      $display("FAIL w2_func_after_reset: got %b required 110", {out_valid_2, s_2});
    end
    start_2 = 1'b1;
    tick();
    start_2 = 1'b0;
    busy_cnt = 0;
    n_res = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy_2) busy_cnt++;
      n_cmp++;
      if (done_2 !== (out_valid_2 && n_res == 15)) begin
        n_err++;
        $display("FAIL w2_done_cycle_%0d: got %b required %b", c, done_2, out_valid_2 && n_res == 15);
      end
      if (out_valid_2) begin
        ex = 2'(n_res >> 2);
        ey = 2'(n_res);
        n_cmp++;
        if ({x_2, y_2, s_2} !== {ex, ey, ~ex & ey}) begin
          n_err++;
          $display("FAIL w2_result_%0d: got %b required %b", n_res, {x_2, y_2, s_2}, {ex, ey, ~ex & ey});
        end
        n_res++;
      end
      tick();
    end
    n_cmp++;
    if (n_res !== 16) begin
      n_err++;
      $display("FAIL w2_result_count: got %0d required 16", n_res);
    end
    n_cmp++;
    if (busy_cnt !== 17) begin
      n_err++;
      $display("FAIL w2_busy_cycles: got %0d required 17", busy_cnt);
    end
  endtask

  task automatic test_full_sweep;
    logic [3:0] sig_m, ex, ey, ef;
    logic [7:0] kk;
    sig_m = 4'h0;
    start_4 = 1'b1;
    tick();
    start_4 = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick();
      kk = 8'(k);
      ex = kk[7:4];
      ey = kk[3:0];
      ef = ~ex & ey;
      sig_m = {sig_m[2:0], sig_m[3]} ^ ef;
      n_cmp++;
      if ({out_valid_4, done_4, x_4, y_4, s_4} !== {1'b1, k == 255, ex, ey, ef}) begin
        n_err++;
        $display("FAIL w4_result_%0d: got %h required %h", k,
                 {out_valid_4, done_4, x_4, y_4, s_4}, {1'b1, k == 255, ex, ey, ef});
      end
    end
    n_cmp++;
    if (sig_4 !== sig_m) begin
      n_err++;
      $display("FAIL w4_sig: got %h required %h", sig_4, sig_m);
    end
    tick();
    n_cmp++;
    if ({busy_4, out_valid_4, done_4, sig_4} !== {3'b000, sig_m}) begin
      n_err++;
      $display("FAIL w4_tail_hold: got %b required %b", {busy_4, out_valid_4, done_4, sig_4}, {3'b000, sig_m});
    end
    start_4 = 1'b1;
    tick();
    start_4 = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid_4, x_4, y_4, sig_4} !== 13'b1_0000_0000_0000) begin
      n_err++;
      $display("FAIL w4_restart_from_zero: got %b required 1000000000000", {out_valid_4, x_4, y_4, sig_4});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {func_we_1, start_1, in_valid_1, func_in_1, a_1, b_1} = '0;
    {func_we_2, start_2, in_valid_2, func_in_2, a_2, b_2} = '0;
    {func_we_4, start_4, in_valid_4, func_in_4, a_4, b_4} = '0;
    test_reset();
    test_sweep_w1();
    test_direct();
    test_func();
    test_start_priority();
    test_reset_mid_sweep();
    test_full_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_table_sweeper.md
Name: gate_table_sweeper

Overview:
Parametrised, registered two-input bitwise logic unit. The gate function is programmable as a 4-bit truth table; the fixed default is ~a & b.
- Direct mode: evaluates caller operands with a valid/ready handshake.
- Sweep mode: self-generates every (a, b) operand combination and emits each result in turn, like an exhaustive truth-table bench, while folding the results into a signature.
- Sits as a reusable gate-evaluation and self-check block in the combinational-exercise tree.

Parameters:
WIDTH, 4, operand/result width in bits (≥1).
DEFAULT_FUNC, 4'b0010, truth table loaded at reset (~a & b).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
func_we  input  1  write func_in into the function register (honoured in IDLE only).
func_in  input  4  new truth table.
start  input  1  begin sweep (honoured in IDLE only).
in_valid  input  1  direct-mode operand strobe.
in_ready  output  1  direct operand accepted this cycle when in_valid=1.
a_in  input  WIDTH  direct operand a.
b_in  input  WIDTH  direct operand b.
s  output  WIDTH  registered result.
x_out  output  WIDTH  a-operand that produced s.
y_out  output  WIDTH  b-operand that produced s.
out_valid  output  1  s/x_out/y_out valid, one-cycle pulse per result.
busy  output  1  state != IDLE.
done  output  1  sweep complete, one-cycle pulse.
sig  output  WIDTH  sweep signature.

Behaviour:
- Function: s[i] = func[{a[i], b[i]}], evaluated independently per bit.
  - Index 0 = (a=0,b=0); index 3 = (a=1,b=1).
- Reset (async, rst_n=0):
  - state=IDLE; func=DEFAULT_FUNC; cnt=0.
  - s, x_out, y_out, sig = 0; out_valid, done = 0.
  - Reset takes effect immediately, including mid-sweep. No partial result is emitted after reset.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - func_we=1: func <= func_in.
  - in_ready = (state==IDLE) & ~start. This is combinational on start.
  - Priority: start > in_valid. If both are high, only the sweep begins; the operand is not consumed.
  - start=1: cnt <= 0, sig <= 0, state <= SWEEP.
  - in_valid & in_ready:
    - Next edge registers s = f(a_in, b_in), x_out = a_in, y_out = b_in.
    - out_valid=1 for exactly the following cycle. Latency 1, throughput 1 per cycle.
  - func_we together with start or in_valid: the new func applies to every result from that edge on.
    - For a direct op in that same cycle, the old func is used.
- SWEEP:
  - cnt is 2*WIDTH bits. Operands are x = cnt[2W-1:W], y = cnt[W-1:0].
  - Each edge:
    - s <= f(x, y); x_out <= x; y_out <= y; out_valid next cycle.
    - sig <= {sig[W-2:0], sig[W-1]} ^ f(x, y). For WIDTH=1 this is sig ^ f.
    - cnt <= cnt + 1.
  - On the edge where cnt == all-ones, the final result is registered and state <= DONE. cnt wraps to 0.
  - func_we, start and in_valid are ignored. in_ready=0.
- DONE:
  - Lasts one cycle. done=1, coincident with the final out_valid.
  - sig holds the final signature. Next edge goes to IDLE.
- Sweep timing: start sampled at edge T0 gives 2^(2W) results on consecutive cycles, starting the cycle after T0+1.
  - busy stays high for 2^(2W)+1 cycles.
- sig, s, x_out and y_out hold their last values until overwritten or reset.

Test Plan:
1. Reset then WIDTH=1 sweep with DEFAULT_FUNC: start -> (x,y,s) = (0,0,0), (0,1,1), (1,0,0), (1,1,0) on 4 consecutive out_valid cycles. done with the 4th; sig=1; busy high for 5 cycles.
2. Direct, WIDTH=4, func=0010, a_in=4'b0101, b_in=4'b0011, in_valid -> next cycle s=4'b0010, out_valid=1 for one cycle. Back-to-back ops give one result per cycle.
3. func_we with func_in=4'b1110 (OR), then a=0101, b=0011 -> s=0111. func_we during SWEEP is ignored: func reads back unchanged in a subsequent direct op.
4. start and in_valid in the same IDLE cycle -> in_ready=0; sweep runs; no direct result appears.
5. WIDTH=2: rst_n low at the 7th sweep result -> all outputs 0 immediately, state IDLE, func=0010. A new start yields a full 16-result sweep, done with the 16th, busy for 17 cycles.
6. WIDTH=4 full sweep: 256 results; cnt wraps to 0; x_out/y_out equal 255/… ordering exactly. Final sig matches the bench model.
